// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg
// Shared constants for the decode/issue queue and its immediate generator:
// RV32I major opcodes, parameter defaults and the JALR-hold state encoding.
package decode_issue_queue_pkg;

    localparam int unsigned ROB_BITS_DEF = 3;
    localparam int unsigned XLEN_DEF     = 32;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    // RUN: fetching freely; JALR_WAIT: a JALR is queued, fetch is stopped
    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_JALR_WAIT = 1'b1
    } iq_state_e;

    function automatic logic is_jalr(input logic [31:0] inst);
        return inst[6:0] == OPC_JALR;
    endfunction

endpackage

// File: rtl/decode_issue_queue_imm_gen.sv
// decode_issue_queue_imm_gen
// Pure combinational immediate decoder, also used by the branch predictor.
// Ports:
//   i_inst   [31:0]     instruction word
//   o_imm    [XLEN-1:0] decoded immediate (0 for R-type / unknown opcodes)
//   o_no_rs2            opcode has no rs2 operand (operand 2 is the immediate)
//   o_no_rd             opcode writes no destination (branch, store)
module decode_issue_queue_imm_gen
    import decode_issue_queue_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output logic            o_no_rs2,
    output logic            o_no_rd
);

    logic [31:0] w_imm32;
    logic        w_shift;

    assign w_shift = (i_inst[14:12] == 3'b001) || (i_inst[14:12] == 3'b101);

    // Format select by major opcode
    always_comb begin
        w_imm32  = '0;
        o_no_rs2 = 1'b0;
        o_no_rd  = 1'b0;
        case (i_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                w_imm32  = {i_inst[31:12], 12'b0};
                o_no_rs2 = 1'b1;
            end
            OPC_JAL: begin
                w_imm32  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                            i_inst[20], i_inst[30:21], 1'b0};
                o_no_rs2 = 1'b1;
            end
            OPC_JALR, OPC_LD: begin
                w_imm32  = {{20{i_inst[31]}}, i_inst[31:20]};
                o_no_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                // shift amounts are unsigned; funct7 bits are not part of the value
                w_imm32  = w_shift ? {27'b0, i_inst[24:20]}
                                   : {{20{i_inst[31]}}, i_inst[31:20]};
                o_no_rs2 = 1'b1;
            end
            OPC_ST: begin
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                o_no_rd = 1'b1;
            end
            OPC_BR: begin
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
                o_no_rd = 1'b1;
            end
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue
// IQ_DEPTH-entry instruction FIFO with combinational decode of the head entry
// and single-issue toward ROB + RS/LSB. A queued JALR stops fetch until it
// issues, then a registered redirect pulse carries its target. flush_in
// empties the queue. Define IQ_PERF_CNT_EN to add stall/issue counters.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable), flush_in
//   fetch_valid/fetch_ready/fetch_inst/fetch_addr   fetcher handshake
//   rob_full/rs_full/lsb_full, rob_tail             downstream status
//   get_id1/get_id2 -> val1/val2, has_dep*_in, dep*_in   operand lookup
//   issue_valid/issue_rs/issue_lsb + decoded fields     issue bundle
//   jalr_redirect/jalr_target                        registered redirect
//   stall_cycles/issued_cnt (IQ_PERF_CNT_EN only)    saturating counters
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned ROB_BITS = ROB_BITS_DEF,
    parameter int unsigned XLEN     = XLEN_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                fetch_valid,
    output logic                fetch_ready,
    input  logic [31:0]         fetch_inst,
    input  logic [XLEN-1:0]     fetch_addr,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic [ROB_BITS-1:0] rob_tail,
    output logic [4:0]          get_id1,
    output logic [4:0]          get_id2,
    input  logic [XLEN-1:0]     val1,
    input  logic [XLEN-1:0]     val2,
    input  logic                has_dep1_in,
    input  logic                has_dep2_in,
    input  logic [ROB_BITS-1:0] dep1_in,
    input  logic [ROB_BITS-1:0] dep2_in,
    output logic                issue_valid,
    output logic                issue_rs,
    output logic                issue_lsb,
    output logic [6:0]          op_type,
    output logic [2:0]          funct3,
    output logic                funct7b5,
    output logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     reg1_v,
    output logic [XLEN-1:0]     reg2_v,
    output logic                has_dep1,
    output logic                has_dep2,
    output logic [ROB_BITS-1:0] rob_entry1,
    output logic [ROB_BITS-1:0] rob_entry2,
    output logic [4:0]          rd_id,
    output logic [ROB_BITS-1:0] rd_rob,
    output logic [31:0]         inst_out,
    output logic [XLEN-1:0]     inst_addr_out,
    output logic                jalr_redirect,
    output logic [XLEN-1:0]     jalr_target
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         issued_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]     r_inst_q [IQ_DEPTH];
    logic [XLEN-1:0] r_addr_q [IQ_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    iq_state_e        r_state;
    logic             r_fetch_ready;
    logic             r_jalr_redirect;
    logic [XLEN-1:0]  r_jalr_target;

    logic             w_nonempty;
    logic [31:0]      w_head_inst;
    logic [XLEN-1:0]  w_head_addr;
    logic [6:0]       w_opcode;
    logic [XLEN-1:0]  w_imm;
    logic             w_no_rs2;
    logic             w_no_rd;
    logic             w_issue_rs;
    logic             w_issue_lsb;
    logic             w_head_jalr;
    logic             w_issue;
    logic             w_enq;
    logic             w_jalr_issue;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [CNT_W-1:0] w_count_next;
    logic             w_room_next;

    // Head view; an empty queue presents an all-zero instruction so every
    // decoded field falls to 0
    assign w_nonempty  = (r_count != '0);
    assign w_head_inst = w_nonempty ? r_inst_q[r_head] : '0;
    assign w_head_addr = w_nonempty ? r_addr_q[r_head] : '0;
    assign w_opcode    = w_head_inst[6:0];

    decode_issue_queue_imm_gen #(
        .XLEN     (XLEN)
    ) u_imm_gen (
        .i_inst   (w_head_inst),
        .o_imm    (w_imm),
        .o_no_rs2 (w_no_rs2),
        .o_no_rd  (w_no_rd)
    );

    assign w_issue_rs  = (w_opcode == OPC_OPIMM) || (w_opcode == OPC_OP) ||
                         (w_opcode == OPC_BR);
    assign w_issue_lsb = (w_opcode == OPC_LD) || (w_opcode == OPC_ST);
    assign w_head_jalr = is_jalr(w_head_inst);

    // JALR needs a resolved rs1 to form its target, so it waits on has_dep1_in
    assign w_issue = rdy_in && w_nonempty && !flush_in && !rob_full &&
                     !(w_issue_rs && rs_full) && !(w_issue_lsb && lsb_full) &&
                     !(w_head_jalr && has_dep1_in);

    assign w_enq        = rdy_in && fetch_valid && r_fetch_ready && !flush_in;
    assign w_jalr_issue = w_issue && w_head_jalr;
    assign w_jalr_sum   = val1 + w_imm;

    // Occupancy after this edge (flush handled separately)
    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_issue})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    assign w_room_next = (w_count_next < CNT_W'(IQ_DEPTH));

    // Entry storage; contents of free slots are never observed
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_inst_q[r_tail] <= fetch_inst;
            r_addr_q[r_tail] <= fetch_addr;
        end
    end

    // Pointers, JALR-hold FSM and registered handshake/redirect outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_state         <= ST_RUN;
            r_fetch_ready   <= 1'b1;
            r_jalr_redirect <= 1'b0;
            r_jalr_target   <= '0;
        end else if (!rdy_in) begin
            r_jalr_redirect <= 1'b0;
        end else if (flush_in) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_state         <= ST_RUN;
            r_fetch_ready   <= 1'b1;
            r_jalr_redirect <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_issue) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count         <= w_count_next;
            r_jalr_redirect <= w_jalr_issue;
            if (w_jalr_issue) begin
                r_jalr_target <= {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            case (r_state)
                ST_RUN: begin
                    if (w_enq && is_jalr(fetch_inst)) begin
                        r_state       <= ST_JALR_WAIT;
                        r_fetch_ready <= 1'b0;
                    end else begin
                        r_fetch_ready <= w_room_next;
                    end
                end
                ST_JALR_WAIT: begin
                    if (w_jalr_issue) begin
                        r_state       <= ST_RUN;
                        r_fetch_ready <= w_room_next;
                    end else begin
                        r_fetch_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign fetch_ready   = r_fetch_ready;
    assign jalr_redirect = r_jalr_redirect;
    assign jalr_target   = r_jalr_target;

    assign issue_valid   = w_issue;
    assign issue_rs      = w_issue_rs;
    assign issue_lsb     = w_issue_lsb;
    assign get_id1       = w_head_inst[19:15];
    assign get_id2       = w_head_inst[24:20];
    assign op_type       = w_opcode;
    assign funct3        = w_head_inst[14:12];
    assign funct7b5      = w_head_inst[30];
    assign imm           = w_imm;
    assign inst_out      = w_head_inst;
    assign inst_addr_out = w_head_addr;

    // Operand 1 always comes from the register file / rename lookup
    assign reg1_v     = w_nonempty ? val1 : '0;
    assign has_dep1   = w_nonempty && has_dep1_in;
    assign rob_entry1 = w_nonempty ? dep1_in : '0;

    // Operand 2 carries the immediate for opcodes without rs2
    assign reg2_v     = !w_nonempty ? '0 : (w_no_rs2 ? w_imm : val2);
    assign has_dep2   = w_nonempty && !w_no_rs2 && has_dep2_in;
    assign rob_entry2 = (w_nonempty && !w_no_rs2) ? dep2_in : '0;

    assign rd_id  = w_no_rd ? 5'd0 : w_head_inst[11:7];
    assign rd_rob = w_nonempty ? rob_tail : '0;

`ifdef IQ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_issued_cnt;
    logic        w_stall;

    assign w_stall = w_nonempty && rdy_in && !w_issue;

    // Saturating counters; deliberately not cleared by flush
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall_cycles <= '0;
            r_issued_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_issue && (r_issued_cnt != '1)) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign issued_cnt   = r_issued_cnt;
`endif

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue
// Directed bench for decode_issue_queue (IQ_DEPTH=4). Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// Counter checks compile in when IQ_PERF_CNT_EN is defined.
module tb_decode_issue_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_addr;
    logic        rob_full, rs_full, lsb_full;
    logic [2:0]  rob_tail;
    logic [4:0]  get_id1, get_id2;
    logic [31:0] val1, val2;
    logic        has_dep1_in, has_dep2_in;
    logic [2:0]  dep1_in, dep2_in;
    logic        issue_valid, issue_rs, issue_lsb;
    logic [6:0]  op_type;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm, reg1_v, reg2_v;
    logic        has_dep1, has_dep2;
    logic [2:0]  rob_entry1, rob_entry2;
    logic [4:0]  rd_id;
    logic [2:0]  rd_rob;
    logic [31:0] inst_out, inst_addr_out;
    logic        jalr_redirect;
    logic [31:0] jalr_target;
`ifdef IQ_PERF_CNT_EN
    logic [31:0] stall_cycles, issued_cnt;
    logic [31:0] snap_stall, snap_iss;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00093; // addi x1,x0,-1
    localparam logic [31:0] I_SLLI31  = 32'h01F09113; // slli x2,x1,31
    localparam logic [31:0] I_JALR    = 32'h00828067; // jalr x0,8(x5)
    localparam logic [31:0] I_ADD     = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_SW      = 32'hFE21AE23; // sw x2,-4(x3)
    localparam logic [31:0] I_LUI     = 32'h123452B7; // lui x5,0x12345

    always #5 clk_in = ~clk_in;

    decode_issue_queue #(.IQ_DEPTH(4), .ROB_BITS(3), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_inst(fetch_inst), .fetch_addr(fetch_addr),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail(rob_tail), .get_id1(get_id1), .get_id2(get_id2),
        .val1(val1), .val2(val2), .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
        .dep1_in(dep1_in), .dep2_in(dep2_in),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_lsb(issue_lsb),
        .op_type(op_type), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
        .reg1_v(reg1_v), .reg2_v(reg2_v), .has_dep1(has_dep1), .has_dep2(has_dep2),
        .rob_entry1(rob_entry1), .rob_entry2(rob_entry2), .rd_id(rd_id), .rd_rob(rd_rob),
        .inst_out(inst_out), .inst_addr_out(inst_addr_out),
        .jalr_redirect(jalr_redirect), .jalr_target(jalr_target)
`ifdef IQ_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .issued_cnt(issued_cnt)
`endif
    );

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] v);
        return {v, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush_in = 1'b0; fetch_valid = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        has_dep1_in = 1'b0; has_dep2_in = 1'b0; dep1_in = '0; dep2_in = '0;
        val1 = '0; val2 = '0; rob_tail = '0;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] addr);
        fetch_valid = 1'b1; fetch_inst = inst; fetch_addr = addr;
        tick();
    endtask

    task automatic test_reset();
        idle(); fetch_inst = '0; fetch_addr = '0; rst_in = 1'b1;
        tick(); tick();
        @(negedge clk_in);
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL reset_fetch_ready: got %h exp 1", fetch_ready); end
        n_vec++; if (jalr_redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %h exp 0", jalr_redirect); end
        n_vec++; if (jalr_target !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h exp 0", jalr_target); end
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue: got %h exp 0", issue_valid); end
        n_vec++; if (inst_out !== 32'h0) begin n_err++; $display("FAIL reset_inst_out: got %h exp 0", inst_out); end
        n_vec++; if (imm !== 32'h0) begin n_err++; $display("FAIL reset_imm: got %h exp 0", imm); end
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [31:0] v [5];
        v[0] = I_ADDI_M1; v[1] = I_SLLI31; v[2] = addi(5'd3, 12'd3);
        v[3] = addi(5'd4, 12'd4); v[4] = addi(5'd5, 12'd5);
        idle(); rob_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fetch_valid = 1'b1; fetch_inst = v[k]; fetch_addr = 32'h100 + 32'(4 * k);
            @(negedge clk_in);
            n_vec++; if (fetch_ready !== (k < 4)) begin n_err++; $display("FAIL fill_ready[%0d]: got %h exp %h", k, fetch_ready, (k < 4)); end
            n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL fill_no_issue[%0d]: got %h exp 0", k, issue_valid); end
            tick();
        end
        @(negedge clk_in);
        n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %h exp 0", fetch_ready); end
        n_vec++; if (inst_out !== I_ADDI_M1) begin n_err++; $display("FAIL fill_head: got %h exp %h", inst_out, I_ADDI_M1); end
        n_vec++; if (rd_id !== 5'd1) begin n_err++; $display("FAIL fill_rd: got %h exp 1", rd_id); end
        n_vec++; if (issue_rs !== 1'b1) begin n_err++; $display("FAIL fill_route_rs: got %h exp 1", issue_rs); end
        tick();
    endtask

    task automatic test_flow();
        logic [31:0] v [5];
        v[0] = I_ADDI_M1; v[1] = I_SLLI31; v[2] = addi(5'd3, 12'd3);
        v[3] = addi(5'd4, 12'd4); v[4] = addi(5'd5, 12'd5);
        rob_full = 1'b0; rob_tail = 3'd5;
        fetch_valid = 1'b1; fetch_inst = v[4]; fetch_addr = 32'h110;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) fetch_valid = 1'b0;
            @(negedge clk_in);
            n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL flow_issue[%0d]: got %h exp 1", k, issue_valid); end
            n_vec++; if (inst_out !== v[k]) begin n_err++; $display("FAIL flow_order[%0d]: got %h exp %h", k, inst_out, v[k]); end
            if (k == 0) begin
                n_vec++; if (imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL flow_addi_imm: got %h exp ffffffff", imm); end
                n_vec++; if (reg2_v !== 32'hFFFFFFFF) begin n_err++; $display("FAIL flow_addi_reg2: got %h exp ffffffff", reg2_v); end
                n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL flow_ready0: got %h exp 0", fetch_ready); end
                n_vec++; if (inst_addr_out !== 32'h100) begin n_err++; $display("FAIL flow_addr: got %h exp 100", inst_addr_out); end
                n_vec++; if (rd_rob !== 3'd5) begin n_err++; $display("FAIL flow_rd_rob: got %h exp 5", rd_rob); end
            end
            if (k == 1) begin
                n_vec++; if (imm !== 32'h0000001F) begin n_err++; $display("FAIL flow_slli_imm: got %h exp 1f", imm); end
                n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL flow_ready1: got %h exp 1", fetch_ready); end
                n_vec++; if (get_id1 !== 5'd1) begin n_err++; $display("FAIL flow_rs1: got %h exp 1", get_id1); end
            end
            tick();
        end
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL flow_empty_issue: got %h exp 0", issue_valid); end
        n_vec++; if (rd_rob !== 3'd0) begin n_err++; $display("FAIL flow_empty_rd_rob: got %h exp 0", rd_rob); end
        n_vec++; if (op_type !== 7'd0) begin n_err++; $display("FAIL flow_empty_op: got %h exp 0", op_type); end
        tick();
    endtask

    task automatic test_jalr();
        idle(); has_dep1_in = 1'b1;
        fetch_valid = 1'b1; fetch_inst = I_JALR; fetch_addr = 32'h200;
        @(negedge clk_in);
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL jalr_pre_ready: got %h exp 1", fetch_ready); end
        tick();
        fetch_inst = addi(5'd9, 12'd9);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk_in);
            n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL jalr_hold_issue[%0d]: got %h exp 0", w, issue_valid); end
            n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL jalr_hold_ready[%0d]: got %h exp 0", w, fetch_ready); end
            if (w == 0) begin
                n_vec++; if (imm !== 32'h8) begin n_err++; $display("FAIL jalr_imm: got %h exp 8", imm); end
                n_vec++; if (get_id1 !== 5'd5) begin n_err++; $display("FAIL jalr_rs1: got %h exp 5", get_id1); end
                n_vec++; if (issue_rs !== 1'b0) begin n_err++; $display("FAIL jalr_route: got %h exp 0", issue_rs); end
            end
            tick();
        end
        has_dep1_in = 1'b0; val1 = 32'h1003; fetch_valid = 1'b0;
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL jalr_issue: got %h exp 1", issue_valid); end
        n_vec++; if (jalr_redirect !== 1'b0) begin n_err++; $display("FAIL jalr_early_redirect: got %h exp 0", jalr_redirect); end
        tick();
        @(negedge clk_in);
        n_vec++; if (jalr_redirect !== 1'b1) begin n_err++; $display("FAIL jalr_redirect: got %h exp 1", jalr_redirect); end
        n_vec++; if (jalr_target !== 32'h100A) begin n_err++; $display("FAIL jalr_target: got %h exp 100a", jalr_target); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL jalr_resume_ready: got %h exp 1", fetch_ready); end
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL jalr_refused_fetch: got %h exp 0", issue_valid); end
        tick();
        @(negedge clk_in);
        n_vec++; if (jalr_redirect !== 1'b0) begin n_err++; $display("FAIL jalr_pulse_end: got %h exp 0", jalr_redirect); end
        tick();
    endtask

    task automatic test_flush();
        idle(); rob_full = 1'b1;
        push(addi(5'd1, 12'd1), 32'h400);
        push(addi(5'd2, 12'd2), 32'h404);
        push(addi(5'd3, 12'd3), 32'h408);
        rob_full = 1'b0; flush_in = 1'b1; fetch_inst = addi(5'd7, 12'd7);
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL flush_issue: got %h exp 0", issue_valid); end
        tick();
        flush_in = 1'b0; fetch_valid = 1'b0;
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %h exp 0", issue_valid); end
        n_vec++; if (inst_out !== 32'h0) begin n_err++; $display("FAIL flush_no_enq: got %h exp 0", inst_out); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %h exp 1", fetch_ready); end
        tick();
        rob_full = 1'b1;
        push(I_JALR, 32'h500);
        fetch_valid = 1'b0;
        @(negedge clk_in);
        n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL flush_wait_ready: got %h exp 0", fetch_ready); end
        tick();
        rob_full = 1'b0; flush_in = 1'b1;
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL flush_jalr_issue: got %h exp 0", issue_valid); end
        tick();
        flush_in = 1'b0;
        @(negedge clk_in);
        n_vec++; if (jalr_redirect !== 1'b0) begin n_err++; $display("FAIL flush_redirect: got %h exp 0", jalr_redirect); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL flush_state_run: got %h exp 1", fetch_ready); end
        tick();
    endtask

    task automatic test_routing();
        idle(); rob_full = 1'b1;
        push(I_ADD, 32'h300);
        push(I_SW, 32'h304);
        push(I_LUI, 32'h308);
        fetch_valid = 1'b0; rob_full = 1'b0; lsb_full = 1'b1;
        val1 = 32'h11; val2 = 32'hCAFE; has_dep2_in = 1'b1; dep2_in = 3'd6;
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL route_add_issue: got %h exp 1", issue_valid); end
        n_vec++; if ({issue_rs, issue_lsb} !== 2'b10) begin n_err++; $display("FAIL route_add_dest: got %b exp 10", {issue_rs, issue_lsb}); end
        n_vec++; if (rd_id !== 5'd3) begin n_err++; $display("FAIL route_add_rd: got %h exp 3", rd_id); end
        n_vec++; if (imm !== 32'h0) begin n_err++; $display("FAIL route_add_imm: got %h exp 0", imm); end
        n_vec++; if (reg2_v !== 32'hCAFE) begin n_err++; $display("FAIL route_add_reg2: got %h exp cafe", reg2_v); end
        n_vec++; if ({has_dep2, rob_entry2} !== 4'b1110) begin n_err++; $display("FAIL route_add_dep2: got %b exp 1110", {has_dep2, rob_entry2}); end
        n_vec++; if (reg1_v !== 32'h11) begin n_err++; $display("FAIL route_add_reg1: got %h exp 11", reg1_v); end
        tick();
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL route_sw_stall: got %h exp 0", issue_valid); end
        n_vec++; if ({issue_rs, issue_lsb} !== 2'b01) begin n_err++; $display("FAIL route_sw_dest: got %b exp 01", {issue_rs, issue_lsb}); end
        n_vec++; if (rd_id !== 5'd0) begin n_err++; $display("FAIL route_sw_rd: got %h exp 0", rd_id); end
        n_vec++; if (imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL route_sw_imm: got %h exp fffffffc", imm); end
        n_vec++; if (funct3 !== 3'd2) begin n_err++; $display("FAIL route_sw_f3: got %h exp 2", funct3); end
        tick();
        lsb_full = 1'b0;
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL route_sw_issue: got %h exp 1", issue_valid); end
        tick();
        rs_full = 1'b1; lsb_full = 1'b1;
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL route_lui_issue: got %h exp 1", issue_valid); end
        n_vec++; if (imm !== 32'h12345000) begin n_err++; $display("FAIL route_lui_imm: got %h exp 12345000", imm); end
        n_vec++; if (reg2_v !== 32'h12345000) begin n_err++; $display("FAIL route_lui_reg2: got %h exp 12345000", reg2_v); end
        n_vec++; if ({has_dep2, rob_entry2} !== 4'b0000) begin n_err++; $display("FAIL route_lui_dep2: got %b exp 0000", {has_dep2, rob_entry2}); end
        n_vec++; if ({issue_rs, issue_lsb} !== 2'b00) begin n_err++; $display("FAIL route_lui_dest: got %b exp 00", {issue_rs, issue_lsb}); end
        tick();
    endtask

    task automatic test_rdy();
        logic [31:0] a, b, c;
        a = addi(5'd1, 12'h0A); b = addi(5'd2, 12'h0B); c = addi(5'd3, 12'h0C);
        idle(); rob_full = 1'b1;
        push(a, 32'h600); push(b, 32'h604); push(c, 32'h608);
        fetch_valid = 1'b0; rob_full = 1'b0;
        @(negedge clk_in);
        n_vec++; if (inst_out !== a) begin n_err++; $display("FAIL rdy_first: got %h exp %h", inst_out, a); end
        tick();
        rdy_in = 1'b0; fetch_valid = 1'b1; fetch_inst = addi(5'd4, 12'h0D);
`ifdef IQ_PERF_CNT_EN
        snap_stall = stall_cycles; snap_iss = issued_cnt;
`endif
        for (int w = 0; w < 2; w++) begin
            @(negedge clk_in);
            n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rdy_low_issue[%0d]: got %h exp 0", w, issue_valid); end
            n_vec++; if (inst_out !== b) begin n_err++; $display("FAIL rdy_low_head[%0d]: got %h exp %h", w, inst_out, b); end
            tick();
        end
        rdy_in = 1'b1; fetch_valid = 1'b0;
`ifdef IQ_PERF_CNT_EN
        n_vec++; if (stall_cycles !== snap_stall) begin n_err++; $display("FAIL rdy_stall_cnt: got %h exp %h", stall_cycles, snap_stall); end
`endif
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b1 || inst_out !== b) begin n_err++; $display("FAIL rdy_resume_b: got %h/%h exp 1/%h", issue_valid, inst_out, b); end
        tick();
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b1 || inst_out !== c) begin n_err++; $display("FAIL rdy_resume_c: got %h/%h exp 1/%h", issue_valid, inst_out, c); end
        tick();
        @(negedge clk_in);
        n_vec++; if (issue_valid !== 1'b0 || inst_out !== 32'h0) begin n_err++; $display("FAIL rdy_no_enq: got %h/%h exp 0/0", issue_valid, inst_out); end
`ifdef IQ_PERF_CNT_EN
        n_vec++; if (issued_cnt !== snap_iss + 32'd2) begin n_err++; $display("FAIL rdy_issued_cnt: got %h exp %h", issued_cnt, snap_iss + 32'd2); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        idle(); rob_full = 1'b1;
        for (int k = 0; k < 4; k++) push(addi(5'(k + 1), 12'(k)), 32'h700 + 32'(4 * k));
        fetch_valid = 1'b0; rob_full = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_issue: got %h exp 0", issue_valid); end
        n_vec++; if (inst_out !== 32'h0) begin n_err++; $display("FAIL rstmid_head: got %h exp 0", inst_out); end
        n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %h exp 1", fetch_ready); end
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_flow();
        test_jalr();
        test_flush();
        test_routing();
        test_rdy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
